cci_csr_rd_rsp_tx: RTL

Transmit side of the CCI MMIO CSR path: accepts decoded MMIO read requests (tid, address) from the c0 Rx channel, forwards them to the AFU's CSR read port, matches returned data in order with the saved tids, and drives MMIO read responses on the c2 Tx channel. Sits between the c0 Rx CSR decode and the AFU register file. It is the responder that closes every host MMIO read.

---
 rtl/cci_csr_rd_rsp_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cci_csr_rd_rsp_tx.sv
`timescale 1ns/1ps
// cci_csr_rd_rsp_tx
//
// Responder for host MMIO reads on the CCI CSR path. Decoded read requests
// from the c0 Rx channel are forwarded to the AFU CSR read port, and their
// tids are queued. AFU read data comes back strictly in request order. Each
// returned word is paired with the oldest queued tid and sent as a c2 Tx MMIO
// read response.
//
// Optional feature (macro CCI_CSR_RD_TIMEOUT_EN): a watchdog on the oldest
// pending tid. If that tid waits TIMEOUT_CYCLES cycles, the block answers it
// with all-ones data. It then absorbs the late AFU word for that read.
//
// Ports:
//   clk, reset                       single clock, synchronous active-high reset
//   rx_mmio_rd_valid, rx_tid, rx_addr   incoming MMIO read request
//   csr_rd_en, csr_rd_addr           registered read strobe to the AFU CSR file
//   csr_rd_data_valid, csr_rd_data   in-order read data from the AFU
//   c2_mmio_rd_valid, c2_tid, c2_data   registered MMIO read response (no backpressure)
//   err_overflow                     sticky: a request arrived with the FIFO full and no pop
//   err_spurious                     sticky: AFU data arrived with no pending tid
//   err_timeout                      sticky: watchdog fired (0 without the macro)
module cci_csr_rd_rsp_tx #(
  parameter int TID_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_mmio_rd_valid,
  input  logic [8:0]  rx_tid,
  input  logic [15:0] rx_addr,
  output logic        csr_rd_en,
  output logic [15:0] csr_rd_addr,
  input  logic        csr_rd_data_valid,
  input  logic [63:0] csr_rd_data,
  output logic        c2_mmio_rd_valid,
  output logic [8:0]  c2_tid,
  output logic [63:0] c2_data,
  output logic        err_overflow,
  output logic        err_spurious,
  output logic        err_timeout
);

  localparam int PW = $clog2(TID_DEPTH);
  localparam int CW = PW + 1;

  logic [8:0]    tid_mem [TID_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          data_pop;
  logic          pop;
  logic          timeout_fire;
  logic          spurious;
  logic          overflow;
  logic [8:0]    head_tid;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(TID_DEPTH));
  assign head_tid   = tid_mem[rd_ptr_reg];

`ifdef CCI_CSR_RD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_reg;
  logic [CW-1:0] drop_reg;
  logic          err_timeout_reg;
  logic          absorbing;

  // While reads that timed out still owe their late data, the next AFU words
  // belong to them. Those words are swallowed, not matched to newer tids.
  assign absorbing    = (drop_reg != '0);
  assign data_pop     = csr_rd_data_valid && !fifo_empty && !absorbing;
  assign spurious     = csr_rd_data_valid && fifo_empty && !absorbing;
  // Any arriving data word takes priority over a timeout in the same cycle.
  assign timeout_fire = !fifo_empty && !csr_rd_data_valid &&
                        (wd_reg == WW'(TIMEOUT_CYCLES));
  assign err_timeout  = err_timeout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_reg          <= '0;
      drop_reg        <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      // Hold at the limit if incoming data keeps blocking the timeout.
      if (fifo_empty || pop)
        wd_reg <= '0;
      else if (wd_reg != WW'(TIMEOUT_CYCLES))
        wd_reg <= wd_reg + 1'b1;

      if (timeout_fire)
        drop_reg <= drop_reg + 1'b1;
      else if (csr_rd_data_valid && absorbing)
        drop_reg <= drop_reg - 1'b1;

      if (timeout_fire)
        err_timeout_reg <= 1'b1;
    end
  end
`else
  wire unused_timeout_cycles = |TIMEOUT_CYCLES;

  assign data_pop     = csr_rd_data_valid && !fifo_empty;
  assign spurious     = csr_rd_data_valid && fifo_empty;
  assign timeout_fire = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  assign pop = data_pop || timeout_fire;
  // A pop in the same cycle frees a slot, so a push at full still succeeds.
  // When the FIFO is empty, the pop sees the pre-push state and cannot happen.
  assign push     = rx_mmio_rd_valid && (!fifo_full || pop);
  assign overflow = rx_mmio_rd_valid && fifo_full && !pop;

  // The tid storage has no reset. Only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push)
      tid_mem[wr_ptr_reg] <= rx_tid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      csr_rd_en        <= 1'b0;
      csr_rd_addr      <= '0;
      c2_mmio_rd_valid <= 1'b0;
      c2_tid           <= '0;
      c2_data          <= '0;
      err_overflow     <= 1'b0;
      err_spurious     <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);

      // A dropped request still issues its CSR read strobe.
      csr_rd_en <= rx_mmio_rd_valid;
      if (rx_mmio_rd_valid)
        csr_rd_addr <= rx_addr;

      c2_mmio_rd_valid <= pop;
      if (pop) begin
        c2_tid  <= head_tid;
        c2_data <= timeout_fire ? {64{1'b1}} : csr_rd_data;
      end

      if (overflow)
        err_overflow <= 1'b1;
      if (spurious)
        err_spurious <= 1'b1;
    end
  end

endmodule
